// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous memory between instruction fetch and
//   the MEM-stage data access. One access in flight at a time; a data access
//   wins over a fetch requested in the same cycle. IM_stall/DM_stall hold the
//   pipeline until the corresponding access has completed. Completed results
//   stay put until the whole pipeline advances.
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   im_req, im_addr         fetch request / address
//   dm_read, dm_web         load request, byte write enables (active-low)
//   dm_addr, dm_wdata       data address / store data
//   IM_stall, DM_stall      combinational stall outputs
//   im_rdata, dm_rdata      captured fetch / load results
//   mem_cs, mem_web         memory chip select, byte write enables (active-low)
//   mem_addr, mem_din       memory address / write data
//   mem_dout                memory read data (valid in the last access cycle)
module mem_port_arbiter #(
    parameter int LATENCY = 2,
    parameter int CNT_W   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        im_req,
    input  logic [31:0] im_addr,
    input  logic        dm_read,
    input  logic [3:0]  dm_web,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        IM_stall,
    output logic        DM_stall,
    output logic [31:0] im_rdata,
    output logic [31:0] dm_rdata,
    output logic        mem_cs,
    output logic [3:0]  mem_web,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    typedef enum logic [1:0] {IDLE, DM_BUSY, IM_BUSY} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             im_done;
    logic             dm_done;
    logic             dm_is_read;   // latched: the data access in flight is a load
    logic             dm_req;
    logic             advance;
    logic             last;

    assign dm_req   = dm_read | (dm_web != 4'hf);
    assign IM_stall = im_req & ~im_done;
    assign DM_stall = dm_req & ~dm_done;
    assign advance  = ~IM_stall & ~DM_stall;
    assign last     = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            im_done    <= 1'b0;
            dm_done    <= 1'b0;
            dm_is_read <= 1'b0;
            im_rdata   <= '0;
            dm_rdata   <= '0;
            mem_cs     <= 1'b0;
            mem_web    <= 4'hf;
            mem_addr   <= '0;
            mem_din    <= '0;
        end else begin
            // Done flags survive until the pipeline moves on; a completion in
            // the same cycle (below) takes precedence over the clear.
            if (advance) begin
                im_done <= 1'b0;
                dm_done <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // The done flags keep a finished request from being
                    // re-issued while the other side is still stalled.
                    if (dm_req && !dm_done) begin
                        state      <= DM_BUSY;
                        cnt        <= '0;
                        mem_cs     <= 1'b1;
                        mem_addr   <= dm_addr;
                        mem_web    <= dm_web;
                        mem_din    <= dm_wdata;
                        dm_is_read <= dm_read;
                    end else if (im_req && !im_done) begin
                        state    <= IM_BUSY;
                        cnt      <= '0;
                        mem_cs   <= 1'b1;
                        mem_addr <= im_addr;
                        mem_web  <= 4'hf;
                    end
                end

                DM_BUSY, IM_BUSY: begin
                    if (last) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        mem_cs  <= 1'b0;
                        mem_web <= 4'hf;
                        if (state == DM_BUSY) begin
                            dm_done <= 1'b1;
                            if (dm_is_read)
                                dm_rdata <= mem_dout;
                        end else begin
                            im_done  <= 1'b1;
                            im_rdata <= mem_dout;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
